// File: rtl/sata_oob_sequencer.sv
// ----------------------------------------------------------------------------
// sata_oob_sequencer
//   Serial ATA OOB transmit sequencer. Drives the transceiver txelecidle
//   control with COMINIT/COMRESET, COMWAKE or COMSAS burst/gap patterns.
//   Burst and gap lengths are derived from the clock frequency at elaboration.
//   Sits between the link-layer OOB controller and the PHY transmitter.
//
// Parameters
//   CLKFREQ    clk frequency in kHz
//   AMOUNT     bursts per sequence, 1..15
//   TRAIL_GAP  1: one gap follows the last burst; 0: finish on the last burst
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   cmd_valid   in   command request
//   cmd_type    in   00 COMINIT/COMRESET, 01 COMWAKE, 10 COMSAS, 11 reserved
//   cmd_ready   out  sequencer can accept a command (IDLE and no abort)
//   abort       in   synchronous cancel of the running sequence
//   oobfinish   in   forces the transmitter active (txelecidle = 0)
//   busy        out  sequence in progress
//   done        out  one-cycle pulse on normal completion
//   cmd_err     out  one-cycle pulse when a reserved type is accepted
//   txelecidle  out  registered electrical-idle control
//
// States
//   IDLE  | waiting for a command, transmitter idle
//   BURST | transmitter active for one burst length
//   GAP   | transmitter idle for one gap length of the latched type
//   TRAIL | optional gap after the last burst
// ----------------------------------------------------------------------------
module sata_oob_sequencer #(
    parameter int unsigned CLKFREQ   = 150_000,
    parameter int unsigned AMOUNT    = 6,
    parameter bit          TRAIL_GAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_type,
    output logic       cmd_ready,
    input  logic       abort,
    input  logic       oobfinish,
    output logic       busy,
    output logic       done,
    output logic       cmd_err,
    output logic       txelecidle
);

    // Length in cycles of an interval of 'ui' unit intervals, rounded to nearest.
    function automatic int unsigned oob_len(input longint unsigned ui);
        longint unsigned n;
        n = (ui * 64'(CLKFREQ) + 64'd750_000) / 64'd1_500_000;
        if (n < 64'd1) begin
            n = 64'd1;
        end
        return 32'(n);
    endfunction

    localparam int unsigned BURST_LEN   = oob_len(64'd160);
    localparam int unsigned GAPINIT_LEN = oob_len(64'd480);
    localparam int unsigned GAPWAKE_LEN = oob_len(64'd160);
    localparam int unsigned GAPSAS_LEN  = oob_len(64'd1440);

    localparam int unsigned MAX_AB  = (BURST_LEN > GAPINIT_LEN) ? BURST_LEN : GAPINIT_LEN;
    localparam int unsigned MAX_CD  = (GAPWAKE_LEN > GAPSAS_LEN) ? GAPWAKE_LEN : GAPSAS_LEN;
    localparam int unsigned MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned BW = $clog2(AMOUNT + 1);

    // Terminal counts: the interval ends when the counter reaches length-1.
    localparam logic [CW-1:0] BURST_LAST   = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] GAPINIT_LAST = CW'(GAPINIT_LEN - 1);
    localparam logic [CW-1:0] GAPWAKE_LAST = CW'(GAPWAKE_LEN - 1);
    localparam logic [CW-1:0] GAPSAS_LAST  = CW'(GAPSAS_LEN - 1);
    localparam logic [BW-1:0] LAST_BURST   = BW'(AMOUNT - 1);

    localparam logic [1:0] TYPE_RSVD = 2'b11;

    // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_BURST = 3'b001,
        S_GAP   = 3'b010,
        S_TRAIL = 3'b100
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [1:0]    type_q, type_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          txelecidle_q;

    logic          accept;
    logic [CW-1:0] gap_last;

    always_comb begin
        case (type_q)
            2'b01:   gap_last = GAPWAKE_LAST;
            2'b10:   gap_last = GAPSAS_LAST;
            default: gap_last = GAPINIT_LAST;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            type_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            type_q  <= type_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        type_d  = type_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                bcnt_d = '0;
                if (accept) begin
                    type_d = cmd_type;
                    if (cmd_type == TYPE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_BURST;
                    end
                end
            end

            S_BURST: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end else if (cnt_q == BURST_LAST) begin
                    cnt_d = '0;
                    if (bcnt_q == LAST_BURST) begin
                        if (TRAIL_GAP) begin
                            state_d = S_TRAIL;
                        end else begin
                            state_d = S_IDLE;
                            bcnt_d  = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = S_GAP;
                        bcnt_d  = bcnt_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end else if (cnt_q == gap_last) begin
                    state_d = S_BURST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_TRAIL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                end else if (cnt_q == gap_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
        endcase
    end

    // Registered so the transmitter control lags the FSM by exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txelecidle_q <= 1'b1;
        end else begin
            txelecidle_q <= ~((state_q == S_BURST) | oobfinish);
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign cmd_err    = err_q;
    assign txelecidle = txelecidle_q;

endmodule

// File: tb/tb_sata_oob_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sata_oob_sequencer
//   Directed bench for sata_oob_sequencer at CLKFREQ = 150 MHz
//   (burst 16, COMINIT gap 48, COMWAKE gap 16, COMSAS gap 144 cycles).
//   dut0 uses the default AMOUNT=6/TRAIL_GAP=1, dut1 uses AMOUNT=1/TRAIL_GAP=0;
//   both share the stimulus.
// ----------------------------------------------------------------------------
module tb_sata_oob_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic       abort;
    logic       oobfinish;

    logic ready0, busy0, done0, err0, tx0;
    logic ready1, busy1, done1, err1, tx1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sata_oob_sequencer #(.CLKFREQ(150_000), .AMOUNT(6), .TRAIL_GAP(1'b1)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_ready (ready0),
        .abort     (abort),
        .oobfinish (oobfinish),
        .busy      (busy0),
        .done      (done0),
        .cmd_err   (err0),
        .txelecidle(tx0)
    );

    sata_oob_sequencer #(.CLKFREQ(150_000), .AMOUNT(1), .TRAIL_GAP(1'b0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_ready (ready1),
        .abort     (abort),
        .oobfinish (oobfinish),
        .busy      (busy1),
        .done      (done1),
        .cmd_err   (err1),
        .txelecidle(tx1)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected txelecidle t cycles after BURST entry (t=0: first BURST cycle).
    // Bursts occupy 16 cycles every (16+gap) cycles; the output lags by one.
    function automatic logic exp_idle(input int t, input int gap, input int amount,
                                      input bit oob);
        int u, k, r;
        if (oob) return 1'b0;
        if (t < 1) return 1'b1;
        u = t - 1;
        k = u / (16 + gap);
        r = u % (16 + gap);
        return !((k < amount) && (r < 16));
    endfunction

    // Present a command; returns one cycle after the acceptance edge.
    task automatic issue(input logic [1:0] typ, input bit keep_valid);
        cmd_valid = 1'b1;
        cmd_type  = typ;
        check("issue ready", ready0, 1'b1);
        step();
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    // Checks each cycle from BURST entry up to completion (or stop_t).
    // Ends sampled in the last checked cycle.
    task automatic run_seq(input string tag, input bit sel, input int gap,
                           input int amount, input bit trail, input bit oob,
                           input int stop_t);
        int total, last;
        logic tx, by, dn, rd;
        total = amount * 16 + (amount - 1) * gap + (trail ? gap : 0);
        last  = (stop_t < total) ? stop_t : total;
        for (int t = 0; t <= last; t++) begin
            tx = sel ? tx1    : tx0;
            by = sel ? busy1  : busy0;
            dn = sel ? done1  : done0;
            rd = sel ? ready1 : ready0;
            check($sformatf("%s tx t=%0d", tag, t), tx, exp_idle(t, gap, amount, oob));
            check($sformatf("%s busy t=%0d", tag, t), by, (t < total));
            check($sformatf("%s done t=%0d", tag, t), dn, (t == total));
            check($sformatf("%s ready t=%0d", tag, t), rd, (t == total));
            if (t < last) step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        abort     = 1'b0;
        oobfinish = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst tx", tx0, 1'b1);
        check("rst busy", busy0, 1'b0);
        check("rst done", done0, 1'b0);
        check("rst err", err0, 1'b0);
        check("rst ready", ready0, 1'b1);
        check("rst tx1", tx1, 1'b1);
        reset = 1'b0;
        step();

        // 1: COMINIT, six bursts with 48-cycle gaps and a trailing gap
        issue(2'b00, 1'b0);
        run_seq("s1", 1'b0, 48, 6, 1'b1, 1'b0, 10_000);
        step();
        check("s1 post done", done0, 1'b0);
        check("s1 post tx", tx0, 1'b1);
        check("s1 post busy", busy0, 1'b0);

        // 2: COMWAKE with COMSAS held valid behind it
        issue(2'b01, 1'b1);
        cmd_type = 2'b10;
        run_seq("s2w", 1'b0, 16, 6, 1'b1, 1'b0, 10_000);
        step();
        cmd_valid = 1'b0;
        run_seq("s2s", 1'b0, 144, 6, 1'b1, 1'b0, 10_000);
        step();
        check("s2 post done", done0, 1'b0);
        check("s2 post busy", busy0, 1'b0);

        // 3: abort in the third COMINIT gap, then a clean restart
        issue(2'b00, 1'b0);
        run_seq("s3a", 1'b0, 48, 6, 1'b1, 1'b0, 150);
        abort = 1'b1;
        step();
        check("s3 abort busy", busy0, 1'b0);
        check("s3 abort done", done0, 1'b0);
        check("s3 abort tx", tx0, 1'b1);
        check("s3 abort blocks ready", ready0, 1'b0);
        abort = 1'b0;
        #1;
        check("s3 ready back", ready0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("s3 idle tx %0d", i), tx0, 1'b1);
            check($sformatf("s3 idle done %0d", i), done0, 1'b0);
        end
        issue(2'b00, 1'b0);
        run_seq("s3b", 1'b0, 48, 6, 1'b1, 1'b0, 10_000);
        step();

        // abort together with cmd_valid in IDLE: not accepted
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = 2'b00;
        #1;
        check("idle abort ready", ready0, 1'b0);
        step();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        check("idle abort busy", busy0, 1'b0);
        step();
        check("idle abort tx", tx0, 1'b1);
        check("idle abort busy2", busy0, 1'b0);

        // 4: reserved command type
        issue(2'b11, 1'b0);
        check("s4 err", err0, 1'b1);
        check("s4 busy", busy0, 1'b0);
        check("s4 done", done0, 1'b0);
        check("s4 tx", tx0, 1'b1);
        step();
        check("s4 err drop", err0, 1'b0);
        check("s4 busy2", busy0, 1'b0);
        check("s4 done2", done0, 1'b0);
        check("s4 tx2", tx0, 1'b1);

        // 5: oobfinish held through idle and a full COMINIT
        oobfinish = 1'b1;
        check("s5 tx lag", tx0, 1'b1);
        step();
        check("s5 tx forced", tx0, 1'b0);
        issue(2'b00, 1'b0);
        run_seq("s5", 1'b0, 48, 6, 1'b1, 1'b1, 10_000);
        step();
        check("s5 post done", done0, 1'b0);
        check("s5 post tx", tx0, 1'b0);
        oobfinish = 1'b0;
        step();
        check("s5 release tx", tx0, 1'b1);

        // 6: reset mid-burst, then a single burst without trailing gap
        issue(2'b00, 1'b0);
        run_seq("s6a", 1'b0, 48, 6, 1'b1, 1'b0, 5);
        reset = 1'b1;
        #1;
        check("s6 rst tx", tx0, 1'b1);
        check("s6 rst busy", busy0, 1'b0);
        check("s6 rst done", done0, 1'b0);
        check("s6 rst ready", ready0, 1'b1);
        check("s6 rst tx1", tx1, 1'b1);
        check("s6 rst busy1", busy1, 1'b0);
        step();
        reset = 1'b0;
        step();
        issue(2'b00, 1'b0);
        run_seq("s6b", 1'b1, 48, 1, 1'b0, 1'b0, 10_000);
        step();
        check("s6 post tx1", tx1, 1'b1);
        check("s6 post done1", done1, 1'b0);
        check("s6 post busy1", busy1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
